// File: rtl/instr_fetch_buffer_pkg.sv
// rv_pkg: shared fetch-path widths, the canonical NOP and the buffered fetch entry type.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_buffer_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = count == '0;
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: issues one-cycle-latency imem reads at pc and buffers {pc, instr}
// pairs for decode; a redirect (flush) discards everything buffered or in flight.
module instr_fetch_buffer
    import rv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_en,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [ILEN-1:0]  imem_rdata,
    input  logic             flush,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [ILEN-1:0]  instr,
    output logic [WIDTH-1:0] instr_pc
);
    localparam int AW = $clog2(DEPTH);

    logic             inflight, pop, full, empty;
    logic [WIDTH-1:0] req_pc;
    logic [AW:0]      count;
    logic [AW+1:0]    pending;

    assign pop         = instr_valid && instr_ready;
    assign instr_valid = !empty;
    // Slots already claimed after this cycle's pop; a request only goes out if one stays free.
    assign pending     = {1'b0, count} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
    assign imem_req    = rst && !flush && !(full && !pop) && pending < (AW+2)'(DEPTH);
    assign pc_en       = imem_req;
    assign imem_addr   = rst ? pc : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) req_pc <= pc;
        end
    end

    fetch_fifo #(.DW(WIDTH + ILEN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight && !flush),
        .pop   (pop),
        .flush (flush),
        .wdata ({req_pc, imem_rdata}),
        .rdata ({instr_pc, instr}),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: table-driven trace plus scoreboard of issued fetches against delivered head.
module tb_instr_fetch_buffer;
    import rv_pkg::*;
    localparam int D = 2;

    typedef struct {
        logic        rdy;
        logic        fl;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    logic        clk = 0, rst = 0, flush = 0, instr_ready = 0;
    logic        pc_en, imem_req, instr_valid;
    logic [31:0] pc = 0, imem_rdata = 0, imem_addr, instr, instr_pc;
    int          n_cmp = 0, n_bad = 0, infl = 0;
    fetch_entry_t q[$];
    logic        s_req;
    logic [31:0] s_addr;
    vec_t        tbl[12];

    always #5 clk = ~clk;

    instr_fetch_buffer #(.WIDTH(32), .ILEN(32), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_pc_en"}, pc_en, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_instr_pc"}, instr_pc, 0);
        chk({tag, "_addr"}, imem_addr, 0);
    endtask

    // Drive inputs, compare at the falling edge against the scoreboard, then update it.
    task automatic sample(input logic rdy, input logic fl);
        logic ev, ep, er;
        instr_ready = rdy;
        flush = fl;
        @(negedge clk);
        ev = (q.size() - infl) > 0;
        ep = ev && rdy;
        er = !fl && (q.size() - int'(ep)) < D;
        chk("instr_valid", instr_valid, ev);
        chk("imem_req", imem_req, er);
        chk("pc_en", pc_en, er);
        chk("imem_addr", imem_addr, pc);
        if (ep) begin
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr", instr, q[0].instr);
            q.delete(0);
        end
        if (fl) begin
            q.delete();
            infl = 0;
        end else begin
            infl = 0;
            if (er) begin
                q.push_back('{pc: pc, instr: mem_f(pc)});
                infl = 1;
            end
        end
        s_req = imem_req;
        s_addr = imem_addr;
    endtask

    // Memory answers one cycle after a request; the PC register advances on pc_en or redirects.
    task automatic advance(input logic fl, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        imem_rdata = s_req ? mem_f(s_addr) : 32'hdead_beef;
        pc = fl ? tgt : s_req ? pc + 32'd4 : pc;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00c, 1'b1, 32'h004};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008};
        tbl[7]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h014, 1'b1, 32'h00c};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10c, 1'b1, 32'h104};
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 12; i++) begin
            sample(tbl[i].rdy, tbl[i].fl);
            chk($sformatf("vec%0d_req", i), imem_req, tbl[i].e_req);
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), instr_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) chk($sformatf("vec%0d_ipc", i), instr_pc, tbl[i].e_ipc);
            advance(tbl[i].fl, tbl[i].tgt);
        end
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, 1'b0);
            advance(1'b0, 32'h0);
        end
        #2;
        rst = 0;
        #1;
        chk_zero("async");
        q.delete();
        infl = 0;
        pc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 300; i++) begin
            logic rdy, fl;
            logic [31:0] tgt;
            rdy = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 15) == 0;
            tgt = 32'($urandom_range(0, 1023)) << 2;
            sample(rdy, fl);
            advance(fl, tgt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
